rx_word_fifo: RTL and testbench

//  Receive-side word buffer placed directly downstream of the PHY RX byte-unstriping output.

---
 rtl/rx_word_fifo_pkg.sv | 31 +++
 rtl/rx_word_fifo_if.sv | 36 +++
 rtl/rx_fifo_mem.sv | 39 +++
 rtl/rx_word_fifo.sv | 90 +++++++++
 tb/tb_rx_word_fifo.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/rx_word_fifo_pkg.sv
// rtl/rx_word_fifo_pkg.sv - shared sizes, thresholds and flag decode for the RX word FIFO
package rx_word_fifo_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int ADDR_WIDTH      = 3;
  localparam int DEPTH           = 2 ** ADDR_WIDTH;
  localparam int ALMOST_FULL_TH  = 6;
  localparam int ALMOST_EMPTY_TH = 2;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Level flags as a pure function of an entry count, so the registered
  // flags can be computed from the next count on the same edge.
  function automatic fifo_flags_t decode_flags(input int unsigned count,
                                               input int unsigned depth,
                                               input int unsigned af_th,
                                               input int unsigned ae_th);
    fifo_flags_t f;
    f.full         = (count == depth);
    f.empty        = (count == 0);
    f.almost_full  = (count >= af_th);
    f.almost_empty = (count <= ae_th);
    return f;
  endfunction

endpackage

// File: rtl/rx_word_fifo_if.sv
// rtl/rx_word_fifo_if.sv - push/pop/status bundle between PHY RX, FIFO and consumer
interface rx_word_fifo_if
  import rx_word_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = rx_word_fifo_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = rx_word_fifo_pkg::ADDR_WIDTH
);

  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic [ADDR_WIDTH:0]   fifo_count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  // Producer/consumer side: drives pushes and pops, observes data and status.
  modport master (
    output data_in, valid_in, pop,
    input  data_out, valid_out, fifo_count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  // FIFO side.
  modport slave (
    input  data_in, valid_in, pop,
    output data_out, valid_out, fifo_count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/rx_fifo_mem.sv
// rtl/rx_fifo_mem.sv - DEPTH x DATA_WIDTH register array, sync write, registered read
module rx_fifo_mem
  import rx_word_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = rx_word_fifo_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = rx_word_fifo_pkg::ADDR_WIDTH
) (
  input  logic                  clk_f,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH_L = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH_L];

  // Storage write; contents deliberately survive reset (pointers flush them).
  always_ff @(posedge clk_f) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register: loads only on a read, otherwise holds the last word.
  // A same-edge write to raddr (full push+pop) returns the old entry.
  always_ff @(posedge clk_f) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/rx_word_fifo.sv
// rtl/rx_word_fifo.sv - RX word FIFO: pointers, count, registered flags, sticky errors
module rx_word_fifo
  import rx_word_fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = rx_word_fifo_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH      = rx_word_fifo_pkg::ADDR_WIDTH,
  parameter int ALMOST_FULL_TH  = rx_word_fifo_pkg::ALMOST_FULL_TH,
  parameter int ALMOST_EMPTY_TH = rx_word_fifo_pkg::ALMOST_EMPTY_TH
) (
  input  logic         clk_f,
  input  logic         reset,
  rx_word_fifo_if.slave bus
);

  localparam int DEPTH_L = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  push_ok;
  logic                  pop_ok;
  fifo_flags_t           flags;
  fifo_flags_t           flags_next;
  logic                  valid_out_r;
  logic                  overflow_r;
  logic                  underflow_r;

  // Accept decisions use the registered flags; a pop frees a slot on the
  // same edge, so a full FIFO still takes a push when it is also popped.
  always_comb begin
    push_ok    = bus.valid_in && (!flags.full || bus.pop);
    pop_ok     = bus.pop && !flags.empty;
    count_next = count + {{ADDR_WIDTH{1'b0}}, push_ok} - {{ADDR_WIDTH{1'b0}}, pop_ok};
    flags_next = decode_flags(32'(count_next), DEPTH_L, ALMOST_FULL_TH, ALMOST_EMPTY_TH);
  end

  // Pointers, count, flags, read strobe and sticky error bits.
  always_ff @(posedge clk_f) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      flags       <= decode_flags(0, DEPTH_L, ALMOST_FULL_TH, ALMOST_EMPTY_TH);
      valid_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count       <= count_next;
      flags       <= flags_next;
      valid_out_r <= pop_ok;
      if (bus.valid_in && flags.full && !bus.pop) begin
        overflow_r <= 1'b1;
      end
      if (bus.pop && flags.empty) begin
        underflow_r <= 1'b1;
      end
    end
  end

  rx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk_f (clk_f),
    .reset (reset),
    .we    (push_ok && !reset),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .re    (pop_ok && !reset),
    .raddr (rd_ptr),
    .rdata (bus.data_out)
  );

  assign bus.valid_out    = valid_out_r;
  assign bus.fifo_count   = count;
  assign bus.full         = flags.full;
  assign bus.empty        = flags.empty;
  assign bus.almost_full  = flags.almost_full;
  assign bus.almost_empty = flags.almost_empty;
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;

endmodule

// File: tb/tb_rx_word_fifo.sv
// tb/tb_rx_word_fifo.sv - directed self-checking bench for rx_word_fifo
module tb_rx_word_fifo;

  logic clk_f = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  rx_word_fifo_if bus ();

  rx_word_fifo dut (
    .clk_f (clk_f),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_f = ~clk_f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk_f);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic p);
    bus.valid_in = v;
    bus.data_in  = d;
    bus.pop      = p;
  endtask

  logic [31:0] fill_words [8];
  logic [31:0] q [$];
  logic [31:0] exp_word;
  int          pushed;
  logic        do_push, do_pop, exp_pop;

  initial begin
    drive(1'b0, 32'h0, 1'b0);
    fill_words[0] = 32'hBCBCBCBC;
    for (int i = 1; i < 8; i++) fill_words[i] = 32'(i);

    // Reset held for two edges.
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_count",        32'(bus.fifo_count),   32'd0);
    chk("rst_empty",        32'(bus.empty),        32'd1);
    chk("rst_almost_empty", 32'(bus.almost_empty), 32'd1);
    chk("rst_full",         32'(bus.full),         32'd0);
    chk("rst_almost_full",  32'(bus.almost_full),  32'd0);
    chk("rst_valid_out",    32'(bus.valid_out),    32'd0);
    chk("rst_data_out",     bus.data_out,          32'd0);
    chk("rst_overflow",     32'(bus.overflow),     32'd0);
    chk("rst_underflow",    32'(bus.underflow),    32'd0);

    // Fill to 8 without popping.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, fill_words[i], 1'b0);
      tick();
      chk("fill_count",        32'(bus.fifo_count),   32'(i + 1));
      chk("fill_almost_full",  32'(bus.almost_full),  32'((i + 1) >= 6));
      chk("fill_almost_empty", 32'(bus.almost_empty), 32'((i + 1) <= 2));
      chk("fill_full",         32'(bus.full),         32'((i + 1) == 8));
      chk("fill_valid_out",    32'(bus.valid_out),    32'd0);
    end

    // Push while full: dropped, overflow sticks.
    drive(1'b1, 32'hDEADBEEF, 1'b0);
    tick();
    chk("ovf_flag",  32'(bus.overflow),   32'd1);
    chk("ovf_count", 32'(bus.fifo_count), 32'd8);
    chk("ovf_full",  32'(bus.full),       32'd1);

    // Drain 8 in order, each word one edge after its pop.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      tick();
      chk("drain_valid", 32'(bus.valid_out), 32'd1);
      chk("drain_data",  bus.data_out,       fill_words[i]);
      chk("drain_count", 32'(bus.fifo_count), 32'(7 - i));
    end
    drive(1'b0, 32'h0, 1'b0);
    tick();
    chk("drained_valid",    32'(bus.valid_out), 32'd0);
    chk("drained_empty",    32'(bus.empty),     32'd1);
    chk("drained_data_hold", bus.data_out,      32'h00000007);
    chk("ovf_sticky",       32'(bus.overflow),  32'd1);
    chk("no_underflow_yet", 32'(bus.underflow), 32'd0);

    // Refill, then push+pop while full.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 1'b0);
      tick();
    end
    chk("refill_full", 32'(bus.full), 32'd1);
    drive(1'b1, 32'hA5A5A5A5, 1'b1);
    tick();
    chk("fullpp_valid", 32'(bus.valid_out),  32'd1);
    chk("fullpp_data",  bus.data_out,        32'h100);
    chk("fullpp_count", 32'(bus.fifo_count), 32'd8);
    chk("fullpp_full",  32'(bus.full),       32'd1);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      tick();
      exp_word = (i == 8) ? 32'hA5A5A5A5 : 32'h100 + 32'(i);
      chk("fullpp_drain", bus.data_out, exp_word);
    end
    chk("fullpp_no_underflow", 32'(bus.underflow), 32'd0);

    // Push+pop while empty: only the push lands.
    drive(1'b1, 32'h12345678, 1'b1);
    tick();
    chk("emptypp_valid",     32'(bus.valid_out),  32'd0);
    chk("emptypp_underflow", 32'(bus.underflow),  32'd1);
    chk("emptypp_count",     32'(bus.fifo_count), 32'd1);
    chk("emptypp_data_hold", bus.data_out,        32'hA5A5A5A5);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("emptypp_pop_valid", 32'(bus.valid_out), 32'd1);
    chk("emptypp_pop_data",  bus.data_out,       32'h12345678);
    chk("emptypp_empty",     32'(bus.empty),     32'd1);

    // 20-word stream with random pops across pointer wrap, vs a reference queue.
    q.delete();
    pushed = 0;
    for (int c = 0; c < 400 && (pushed < 20 || q.size() > 0); c++) begin
      do_push = (pushed < 20) && ($urandom_range(0, 3) != 0);
      do_pop  = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      drive(do_push, 32'hC0DE0000 + 32'(pushed), do_pop);
      exp_pop = do_pop;
      if (exp_pop) exp_word = q.pop_front();
      if (do_push && (q.size() < 8 || do_pop)) begin
        q.push_back(32'hC0DE0000 + 32'(pushed));
        pushed++;
      end
      tick();
      chk("wrap_valid", 32'(bus.valid_out), 32'(exp_pop));
      if (exp_pop) chk("wrap_data", bus.data_out, exp_word);
      chk("wrap_count", 32'(bus.fifo_count), 32'(q.size()));
    end
    chk("wrap_all_pushed", 32'(pushed), 32'd20);
    chk("wrap_all_drained", 32'(q.size()), 32'd0);

    // Reset with 5 stored flushes everything and clears sticky bits.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h200 + 32'(i), 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0);
    chk("pre_reset_count", 32'(bus.fifo_count), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_count",     32'(bus.fifo_count), 32'd0);
    chk("midrst_empty",     32'(bus.empty),      32'd1);
    chk("midrst_overflow",  32'(bus.overflow),   32'd0);
    chk("midrst_underflow", 32'(bus.underflow),  32'd0);
    chk("midrst_data_out",  bus.data_out,        32'd0);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("midrst_pop_valid", 32'(bus.valid_out), 32'd0);
    chk("midrst_pop_underflow", 32'(bus.underflow), 32'd1);
    drive(1'b0, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
